// File: rtl/muldiv4_iter_unit_if.sv
// Handshake bundle for muldiv4_iter_unit: request side (in_*, op, a, b)
// and held-result side (out_*, result, div0).
interface muldiv4_iter_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_op;
  logic [2*WIDTH-1:0]   result;
  logic                 div0;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_op, result, div0
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_op, result, div0
  );
endinterface

// File: rtl/muldiv4_iter_unit.sv
// Iterative unsigned multiply (shift-add, LSB-first) / restoring divide,
// one bit per clock, WIDTH iterations, result held until accepted.
// Optional build macro MULDIV_EARLY_EXIT_EN: multiply stops once the
// remaining multiplier bits are zero, divide-by-zero stops after one step.
module muldiv4_iter_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv4_iter_unit_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        step;
  logic                 op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   result_q;
  logic                 out_op_q;
  logic                 div0_q;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     diff;
  logic                 q_bit;
  logic                 is_div0;
  logic                 last_iter;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_op    = out_op_q;
  assign bus.result    = result_q;
  assign bus.div0      = div0_q;

  // One iteration of the active operation. For divide, acc holds
  // {remainder, dividend}; quotient bits shift in where dividend bits leave.
  always_comb begin
    partial = {{WIDTH{1'b0}}, a_q} << step;
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    q_bit   = (rem_sh >= {1'b0, b_q});
    // low WIDTH bits suffice: a kept difference is always below b
    diff    = rem_sh[WIDTH-1:0] - b_q;
    acc_nxt = acc;
    if (op_q) begin
      if (q_bit) acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
      else       acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (b_q[0]) begin
      acc_nxt = acc + partial;
    end
    is_div0 = op_q && (b_q == '0);
`ifdef MULDIV_EARLY_EXIT_EN
    last_iter = (step == CW'(WIDTH-1)) || is_div0 ||
                (!op_q && (b_q[WIDTH-1:1] == '0));
`else
    last_iter = (step == CW'(WIDTH-1));
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, iterate in RUN, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_iter)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step     <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
      out_op_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= bus.op;
            step <= '0;
            acc  <= bus.op ? {{WIDTH{1'b0}}, bus.a} : '0;
          end
        end
        RUN: begin
          step <= step + 1'b1;
          acc  <= acc_nxt;
          if (!op_q) b_q <= b_q >> 1;
          if (last_iter) begin
            result_q <= is_div0 ? {a_q, {WIDTH{1'b1}}} : acc_nxt;
            out_op_q <= op_q;
            div0_q   <= is_div0;
          end
        end
        DONE: begin
          if (bus.out_ready) div0_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv4_iter_unit.sv
// Self-checking bench for muldiv4_iter_unit: a transaction-level model
// (plain arithmetic plus a latency count) is compared with the DUT on every
// falling edge; directed operations pin the model with literal results.
module tb_muldiv4_iter_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv4_iter_unit_if #(.WIDTH(4)) bus ();

  muldiv4_iter_unit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic [7:0] p;
    if (!op) begin
      p = {4'b0, a} * {4'b0, b};
      return p;
    end
    if (b == 4'd0) return {a, 4'hF};
    return {a % b, a / b};
  endfunction

  function automatic int exp_lat(input logic [3:0] b, input logic op);
`ifdef MULDIV_EARLY_EXIT_EN
    if (op && b == 4'd0) return 1;
    if (!op) begin
      int n = 1;
      while ((b >> n) != 0) n++;
      return n;
    end
`endif
    return 4;
  endfunction

  // Transaction model: pending op, cycles elapsed, held result.
  logic       m_busy = 1'b0, m_held = 1'b0;
  int         m_cnt = 0, m_lat = 0;
  logic [7:0] m_pend = '0, m_result = '0;
  logic       m_pop = 1'b0, m_pd0 = 1'b0, m_outop = 1'b0, m_div0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_held <= 1'b0; m_cnt <= 0;
      m_result <= '0; m_outop <= 1'b0; m_div0 <= 1'b0;
    end else if (m_held) begin
      if (bus.out_ready) begin
        m_held <= 1'b0;
        m_div0 <= 1'b0;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_busy   <= 1'b0;
        m_held   <= 1'b1;
        m_result <= m_pend;
        m_outop  <= m_pop;
        m_div0   <= m_pd0;
      end
    end else if (bus.in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_pend <= ref_res(bus.a, bus.b, bus.op);
      m_pop  <= bus.op;
      m_pd0  <= bus.op && (bus.b == 4'd0);
      m_lat  <= exp_lat(bus.b, bus.op);
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, !m_busy && !m_held});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_held});
    chk("result",    {24'b0, bus.result},    {24'b0, m_result});
    chk("out_op",    {31'b0, bus.out_op},    {31'b0, m_outop});
    chk("div0",      {31'b0, bus.div0},      {31'b0, m_div0});
  end

  task automatic do_op(input logic [3:0] ta, input logic [3:0] tbv, input logic top,
                       input int hold, output logic [7:0] res, output logic d0,
                       output logic rop, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
    bus.a = ta; bus.b = tbv; bus.op = top; bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.a = 4'($urandom); bus.b = 4'($urandom); bus.op = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      bus.a = 4'($urandom); bus.b = 4'($urandom);
    end
    chk("out_valid_bound", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    res = bus.result; d0 = bus.div0; rop = bus.out_op;
    chk("latency", lat, exp_lat(tbv, top));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("held_result",   {24'b0, bus.result},   {24'b0, res});
      chk("held_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       d, o;
    int         l;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_result",    {24'b0, bus.result},    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(4'd13, 4'd11, 1'b0, 0, r, d, o, l);
    chk("mul_13x11", {24'b0, r}, 32'h8F);
    chk("mul_13x11_op", {31'b0, o}, 32'd0);
    chk("mul_13x11_lat", l, 32'd4);

    do_op(4'd9, 4'd0, 1'b1, 0, r, d, o, l);
    chk("div0_9", {24'b0, r}, 32'h9F);
    chk("div0_flag", {31'b0, d}, 32'd1);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("div0_lat", l, 32'd1);
`else
    chk("div0_lat", l, 32'd4);
`endif

    do_op(4'd15, 4'd15, 1'b0, 3, r, d, o, l);
    chk("mul_15x15_held", {24'b0, r}, 32'hE1);

    do_op(4'd7, 4'd1, 1'b0, 0, r, d, o, l);
    chk("mul_7x1", {24'b0, r}, 32'h07);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("mul_7x1_lat", l, 32'd1);
`else
    chk("mul_7x1_lat", l, 32'd4);
`endif

    do_op(4'd13, 4'd3, 1'b1, 0, r, d, o, l);
    chk("div_13_3", {24'b0, r}, 32'h14);
    chk("div_13_3_op", {31'b0, o}, 32'd1);
    chk("div_13_3_div0", {31'b0, d}, 32'd0);

    // Reset asserted during the second iteration of 7 * 6.
    bus.a = 4'd7; bus.b = 4'd6; bus.op = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_result",    {24'b0, bus.result},    32'd0);
    chk("midrst_out_op",    {31'b0, bus.out_op},    32'd0);
    chk("midrst_div0",      {31'b0, bus.div0},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'd7, 4'd6, 1'b0, 0, r, d, o, l);
    chk("mul_7x6_after_rst", {24'b0, r}, 32'h2A);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), r, d, o, l);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
